modbus_scan_scheduler: RTL and testbench

Master-mode poll sequencer for the Modbus converter. It holds the scan table of up to ENTRIES request descriptors and walks it round-robin. For each entry it hands one request to the master frame engine, then waits for a good response, an error, or a response timeout, retrying failed requests as configured. It sits between the CSR block (SCAN_CTRL / SCAN_IDX / SCAN_ENTRY / SCAN_QTY) and the Modbus master frame builder that drives the UART bridge.

---
 rtl/modbus_scan_scheduler_if.sv | 25 ++
 rtl/modbus_scan_scheduler.sv | 167 ++++++++++++++++
 tb/tb_modbus_scan_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/modbus_scan_scheduler_if.sv
// Request/response bus between the scan scheduler (master) and the Modbus
// master frame engine (slave).
interface modbus_scan_scheduler_if #(
    parameter int IDX_W = 3
);
    logic             req_valid;
    logic             req_ready;
    logic [7:0]       req_slave;
    logic [7:0]       req_func;
    logic [15:0]      req_addr;
    logic [15:0]      req_qty;
    logic [IDX_W-1:0] req_idx;
    logic             rsp_done;
    logic             rsp_err;

    modport master (
        output req_valid, req_slave, req_func, req_addr, req_qty, req_idx,
        input  req_ready, rsp_done, rsp_err
    );

    modport slave (
        input  req_valid, req_slave, req_func, req_addr, req_qty, req_idx,
        output req_ready, rsp_done, rsp_err
    );
endinterface

// File: rtl/modbus_scan_scheduler.sv
// Round-robin Modbus poll sequencer: walks the scan table, issues one request
// per entry, and waits for a response, error or timeout with bounded retries.
module modbus_scan_scheduler #(
    parameter int ENTRIES = 8,
    parameter int IDX_W   = 3,
    parameter int TMO_W   = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_scan_en,
    input  logic [IDX_W:0]          i_scan_num,
    input  logic [15:0]             i_gap_cyc,
    input  logic [TMO_W-1:0]        i_rsp_tmo_cyc,
    input  logic [1:0]              i_max_retry,
    input  logic                    i_tbl_we,
    input  logic [IDX_W-1:0]        i_tbl_widx,
    input  logic [47:0]             i_tbl_wdata,
    input  logic [IDX_W-1:0]        i_tbl_ridx,
    output logic [47:0]             o_tbl_rdata,
    modbus_scan_scheduler_if.master bus,
    output logic                    o_busy,
    output logic                    o_cycle_done,
    output logic [15:0]             o_cycle_cnt,
    output logic                    o_fail_pulse,
    output logic [IDX_W-1:0]        o_fail_idx
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GAP   = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_NEXT  = 3'd4;

    localparam logic [IDX_W:0] L_ENTRIES = (IDX_W+1)'(ENTRIES);

    logic [2:0]       r_state;
    logic [47:0]      r_tbl [ENTRIES];
    logic [IDX_W-1:0] r_idx;
    logic [1:0]       r_retry;
    logic [15:0]      r_gap_cnt;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic [47:0]      r_req;
    logic [IDX_W-1:0] r_req_idx;
    logic             r_cycle_done;
    logic             r_fail_pulse;
    logic [15:0]      r_cycle_cnt;
    logic [IDX_W-1:0] r_fail_idx;

    logic             w_scan_go;
    logic [IDX_W:0]   w_active;
    logic             w_last;
    logic             w_tmo_hit;
    logic             w_ok;
    logic             w_fail;
    logic             w_adv;

    assign w_scan_go = i_scan_en && (i_scan_num != '0);
    assign w_active  = (i_scan_num > L_ENTRIES) ? L_ENTRIES : i_scan_num;
    assign w_last    = (({1'b0, r_idx} + (IDX_W+1)'(1)) >= w_active);

    // A zero timeout load never reaches 1, so the timeout stays disabled.
    assign w_tmo_hit = (r_tmo_cnt == TMO_W'(1));
    assign w_ok      = bus.rsp_done && !bus.rsp_err;
    assign w_fail    = bus.rsp_err || (!bus.rsp_done && w_tmo_hit);
    assign w_adv     = w_ok || (w_fail && (r_retry >= i_max_retry));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_retry      <= '0;
            r_gap_cnt    <= '0;
            r_tmo_cnt    <= '0;
            r_req        <= '0;
            r_req_idx    <= '0;
            r_cycle_done <= 1'b0;
            r_fail_pulse <= 1'b0;
            r_cycle_cnt  <= '0;
            r_fail_idx   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tbl[i] <= '0;
            end
        end else begin
            r_cycle_done <= 1'b0;
            r_fail_pulse <= 1'b0;
            if (i_tbl_we) begin
                r_tbl[i_tbl_widx] <= i_tbl_wdata;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_scan_go) begin
                        r_state   <= S_GAP;
                        r_idx     <= '0;
                        r_retry   <= '0;
                        r_gap_cnt <= i_gap_cyc;
                    end
                end
                S_GAP: begin
                    if (!i_scan_en) begin
                        r_state <= S_IDLE;
                    end else if (r_gap_cnt <= 16'd1) begin
                        r_state   <= S_ISSUE;
                        r_req     <= r_tbl[r_idx];
                        r_req_idx <= r_idx;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 16'd1;
                    end
                end
                S_ISSUE: begin
                    if (bus.req_ready) begin
                        r_state   <= S_WAIT;
                        r_tmo_cnt <= i_rsp_tmo_cyc;
                    end
                end
                S_WAIT: begin
                    if (r_tmo_cnt != '0) begin
                        r_tmo_cnt <= r_tmo_cnt - TMO_W'(1);
                    end
                    // Index/retry bookkeeping is done on entry to NEXT so the
                    // completion pulses are registered and visible during NEXT.
                    if (w_adv) begin
                        r_state <= S_NEXT;
                        r_retry <= '0;
                        if (w_fail) begin
                            r_fail_pulse <= 1'b1;
                            r_fail_idx   <= r_idx;
                        end
                        if (w_last) begin
                            r_idx        <= '0;
                            r_cycle_done <= 1'b1;
                            r_cycle_cnt  <= r_cycle_cnt + 16'd1;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end else if (w_fail) begin
                        r_state   <= S_GAP;
                        r_retry   <= r_retry + 2'd1;
                        r_gap_cnt <= i_gap_cyc;
                    end
                end
                S_NEXT: begin
                    if (w_scan_go) begin
                        r_state   <= S_GAP;
                        r_gap_cnt <= i_gap_cyc;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_tbl_rdata   = r_tbl[i_tbl_ridx];
    assign bus.req_valid = (r_state == S_ISSUE);
    assign bus.req_slave = r_req[47:40];
    assign bus.req_func  = r_req[39:32];
    assign bus.req_addr  = r_req[31:16];
    assign bus.req_qty   = r_req[15:0];
    assign bus.req_idx   = r_req_idx;
    assign o_busy        = (r_state != S_IDLE);
    assign o_cycle_done  = r_cycle_done;
    assign o_cycle_cnt   = r_cycle_cnt;
    assign o_fail_pulse  = r_fail_pulse;
    assign o_fail_idx    = r_fail_idx;

endmodule

// File: tb/tb_modbus_scan_scheduler.sv
// Directed plus randomized bench for modbus_scan_scheduler against a
// transaction-level model of request timing, retries and completion pulses.
module tb_modbus_scan_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        scan_en;
    logic [3:0]  scan_num;
    logic [15:0] gap_cyc;
    logic [23:0] tmo;
    logic [1:0]  max_retry;
    logic        tbl_we;
    logic [2:0]  widx;
    logic [47:0] wdata;
    logic [2:0]  ridx;
    logic [47:0] rdata;
    logic        busy;
    logic        cycle_done;
    logic [15:0] cycle_cnt;
    logic        fail_pulse;
    logic [2:0]  fail_idx;

    modbus_scan_scheduler_if #(.IDX_W(3)) bus ();

    modbus_scan_scheduler #(.ENTRIES(8), .IDX_W(3), .TMO_W(24)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_scan_en     (scan_en),
        .i_scan_num    (scan_num),
        .i_gap_cyc     (gap_cyc),
        .i_rsp_tmo_cyc (tmo),
        .i_max_retry   (max_retry),
        .i_tbl_we      (tbl_we),
        .i_tbl_widx    (widx),
        .i_tbl_wdata   (wdata),
        .i_tbl_ridx    (ridx),
        .o_tbl_rdata   (rdata),
        .bus           (bus),
        .o_busy        (busy),
        .o_cycle_done  (cycle_done),
        .o_cycle_cnt   (cycle_cnt),
        .o_fail_pulse  (fail_pulse),
        .o_fail_idx    (fail_idx)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [47:0] m_tbl [8];
    int          m_idx;
    int          m_retry;
    int          m_cycles;
    int          exp_req_cyc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int gm();
        return (gap_cyc == 16'd0) ? 1 : int'(gap_cyc);
    endfunction

    task automatic wr(input int i, input logic [47:0] d);
        tbl_we = 1'b1;
        widx   = 3'(i);
        wdata  = d;
        m_tbl[i] = d;
        @(negedge clk);
        tbl_we = 1'b0;
    endtask

    task automatic start_scan();
        m_idx       = 0;
        m_retry     = 0;
        scan_en     = 1'b1;
        exp_req_cyc = cyc + 1 + gm();
    endtask

    // kind: 0 done, 1 err, 2 no response (timeout), 3 err+done together
    task automatic do_req(input int kind, input int k, input int rdy_dly, input bit stop);
        int          n;
        int          h;
        int          j;
        int          tmo_i;
        int          clampn;
        int          old_idx;
        bit          ok;
        bit          exhaust;
        bit          last;
        bit          stable;
        logic [47:0] ef;
        logic [63:0] rv;
        n = 0;
        while (bus.req_valid !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", 64'(bus.req_valid), 64'd1);
        chk("req_cyc", 64'(cyc), 64'(exp_req_cyc));
        ef = m_tbl[m_idx];
        chk("req_fields", 64'({bus.req_slave, bus.req_func, bus.req_addr, bus.req_qty}), 64'(ef));
        chk("req_idx", 64'(bus.req_idx), 64'(m_idx));
        if (stop) scan_en = 1'b0;
        if (rdy_dly > 0) begin
            stable = 1'b1;
            bus.req_ready = 1'b0;
            for (int i = 0; i < rdy_dly; i++) begin
                @(negedge clk);
                stable &= (bus.req_valid === 1'b1) && (bus.req_idx === 3'(m_idx)) &&
                          ({bus.req_slave, bus.req_func, bus.req_addr, bus.req_qty} === ef);
                if (rdy_dly >= 10 && i == 2) begin
                    rv = {$urandom(), $urandom()};
                    tbl_we = 1'b1;
                    widx   = 3'(m_idx);
                    wdata  = rv[47:0];
                    m_tbl[m_idx] = rv[47:0];
                end else begin
                    tbl_we = 1'b0;
                end
            end
            tbl_we = 1'b0;
            chk("stall_stable", 64'(stable), 64'd1);
            bus.req_ready = 1'b1;
        end
        h = cyc;
        tmo_i = int'(tmo);
        if (kind == 2 || (tmo_i != 0 && k > tmo_i)) begin
            j  = h + tmo_i;
            ok = 1'b0;
            while (cyc < j) @(negedge clk);
        end else begin
            j  = h + k;
            ok = (kind == 0);
            while (cyc < j) @(negedge clk);
            bus.rsp_done = (kind == 0 || kind == 3);
            bus.rsp_err  = (kind == 1 || kind == 3);
        end
        chk("wait_no_valid", 64'(bus.req_valid), 64'd0);
        @(negedge clk);
        bus.rsp_done = 1'b0;
        bus.rsp_err  = 1'b0;

        old_idx = m_idx;
        exhaust = !ok && (m_retry >= int'(max_retry));
        clampn  = (scan_num > 4'd8) ? 8 : int'(scan_num);
        last    = (ok || exhaust) && (m_idx + 1 >= clampn);
        if (ok || exhaust) begin
            m_retry = 0;
            if (last) begin
                m_idx = 0;
                m_cycles++;
            end else begin
                m_idx++;
            end
            exp_req_cyc = j + 2 + gm();
        end else begin
            m_retry++;
            exp_req_cyc = j + 1 + gm();
        end
        chk("fail_pulse", 64'(fail_pulse), 64'(exhaust));
        chk("cycle_done", 64'(cycle_done), 64'(last));
        chk("cycle_cnt", 64'(cycle_cnt), 64'(16'(m_cycles)));
        if (exhaust) chk("fail_idx", 64'(fail_idx), 64'(old_idx));
        if (stop) begin
            @(negedge clk);
            chk("idle_busy", 64'(busy), 64'd0);
            chk("idle_valid", 64'(bus.req_valid), 64'd0);
        end
    endtask

    initial begin
        logic [63:0] rv;
        int          c0;
        int          n;
        int          kind;
        rst = 1'b1;
        scan_en = 1'b0; scan_num = 4'd0; gap_cyc = 16'd0; tmo = 24'd0; max_retry = 2'd0;
        tbl_we = 1'b0; widx = 3'd0; wdata = 48'd0; ridx = 3'd0;
        bus.req_ready = 1'b1; bus.rsp_done = 1'b0; bus.rsp_err = 1'b0;
        m_cycles = 0;
        for (int i = 0; i < 8; i++) m_tbl[i] = 48'd0;
        repeat (3) @(negedge clk);

        chk("rst_valid", 64'(bus.req_valid), 64'd0);
        chk("rst_fields", 64'({bus.req_slave, bus.req_func, bus.req_addr, bus.req_qty}), 64'd0);
        chk("rst_idx", 64'(bus.req_idx), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cdone", 64'({cycle_done, fail_pulse}), 64'd0);
        chk("rst_ccnt", 64'(cycle_cnt), 64'd0);
        chk("rst_fidx", 64'(fail_idx), 64'd0);
        chk("rst_tbl", 64'(rdata), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            rv = {$urandom(), $urandom()};
            wr(i, rv[47:0]);
        end
        wr(0, 48'h01_03_0000_0002);
        wr(1, 48'h02_01_0010_0008);
        for (int i = 0; i < 8; i++) begin
            ridx = 3'(i);
            @(negedge clk);
            chk("tbl_rd", 64'(rdata), 64'(m_tbl[i]));
        end

        // Basic alternating scan of two entries
        scan_num = 4'd2; gap_cyc = 16'd4; tmo = 24'd0; max_retry = 2'd0;
        start_scan();
        for (int r = 0; r < 6; r++) do_req(0, 10, 0, r == 5);
        chk("t1_cycles", 64'(cycle_cnt), 64'd3);

        // Timeouts with retries until failure
        gap_cyc = 16'd3; tmo = 24'd100; max_retry = 2'd2;
        start_scan();
        do_req(2, 0, 0, 0);
        do_req(2, 0, 0, 0);
        do_req(2, 0, 0, 0);
        chk("t2_fail_idx", 64'(fail_idx), 64'd0);
        do_req(0, 5, 0, 1);

        // Error then success on the retry
        gap_cyc = 16'd2; max_retry = 2'd1;
        start_scan();
        do_req(1, 7, 0, 0);
        do_req(0, 4, 0, 1);

        // Done on the timeout cycle wins; err+done counts as an error
        tmo = 24'd20;
        start_scan();
        do_req(0, 20, 0, 0);
        do_req(3, 5, 0, 0);
        do_req(0, 3, 0, 1);

        // Stalled handshake with scan_en dropped and entry rewritten
        gap_cyc = 16'd1; tmo = 24'd0;
        start_scan();
        do_req(0, 6, 50, 1);
        ridx = 3'd0;
        @(negedge clk);
        chk("t5_tbl", 64'(rdata), 64'(m_tbl[0]));
        start_scan();
        do_req(0, 2, 0, 1);

        // Randomized run with scan_num clamped to the table size
        scan_num  = 4'd9;
        gap_cyc   = 16'($urandom_range(0, 5));
        tmo       = 24'($urandom_range(8, 30));
        max_retry = 2'($urandom_range(0, 3));
        start_scan();
        c0 = m_cycles;
        for (int r = 0; r < 150 && m_cycles < c0 + 1; r++) begin
            kind = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 3));
            do_req(kind, int'($urandom_range(1, int'(tmo) + 5)), int'($urandom_range(0, 3)), 1'b0);
        end
        chk("t6_wrapped", 64'(m_cycles - c0), 64'd1);
        do_req(0, 2, 0, 1);

        // scan_num = 0 never leaves IDLE
        scan_num = 4'd0;
        scan_en  = 1'b1;
        repeat (20) @(negedge clk);
        chk("t6_zero_busy", 64'(busy), 64'd0);
        chk("t6_zero_valid", 64'(bus.req_valid), 64'd0);
        scan_en = 1'b0;

        // Reset asserted while waiting for a response
        scan_num = 4'd2; gap_cyc = 16'd2; tmo = 24'd0;
        start_scan();
        n = 0;
        while (bus.req_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t7_req_seen", 64'(bus.req_valid), 64'd1);
        @(negedge clk);
        chk("t7_busy_pre", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("t7_valid", 64'(bus.req_valid), 64'd0);
        chk("t7_fields", 64'({bus.req_slave, bus.req_func, bus.req_addr, bus.req_qty, bus.req_idx}), 64'd0);
        chk("t7_status", 64'({busy, cycle_done, fail_pulse, fail_idx}), 64'd0);
        chk("t7_ccnt", 64'(cycle_cnt), 64'd0);
        chk("t7_tbl", 64'(rdata), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        scan_en = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
